// File: rtl/i_execute_pkg.sv
// i_execute_pkg: constants shared by all pipeline stages.
//   - aluop encodings from the main decoder (ID stage)
//   - funct field codes for R-type instructions
//   - 4-bit ALU control codes consumed by the EX-stage ALU
package i_execute_pkg;

    // aluop classes produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    // Width constants used across the datapath
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

endpackage

// File: rtl/i_execute_alu_control.sv
// alu_control: translates the decoder's aluop class and the instruction
// funct field into the 4-bit control code driving the EX-stage ALU.
// Ports:
//   i_aluop  [1:0] operation class from ID/EX
//   i_funct  [5:0] funct field (low bits of the sign-extended immediate)
//   o_aluctl [3:0] ALU control code
module alu_control
    import i_execute_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [3:0] o_aluctl
);

    // Loads/stores and the spare class 11 add, branches subtract; only the
    // R-type class looks at funct. Unrecognised funct yields ALU_INVALID so
    // the ALU produces a defined zero result instead of garbage.
    always_comb begin
        o_aluctl = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD:   o_aluctl = ALU_ADD;
            ALUOP_SUB:   o_aluctl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: o_aluctl = ALU_ADD;
                    FUNCT_SUB: o_aluctl = ALU_SUB;
                    FUNCT_AND: o_aluctl = ALU_AND;
                    FUNCT_OR:  o_aluctl = ALU_OR;
                    FUNCT_SLT: o_aluctl = ALU_SLT;
                    default:   o_aluctl = ALU_INVALID;
                endcase
            end
            default:     o_aluctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/i_execute.sv
// i_execute: EX stage of the 5-stage pipeline plus the EX/MEM register.
// Computes the branch target, the ALU result and zero flag, and the
// destination register number, then captures them (with the pass-through
// control and store data) on the rising clock edge.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stall             hold EX/MEM contents
//   flush             load a bubble (WB/M control cleared) this cycle
//   wb_ctl, m_ctl     control fields from ID/EX
//   regdst, alusrc    destination / ALU operand-B selects
//   aluop             ALU operation class
//   npc, rdata1, rdata2, s_extend, instr_2016, instr_1511  datapath inputs
//   wb_ctlout, m_ctlout, add_result, zero, alu_result, rdata2out,
//   five_bit_muxout   registered EX/MEM outputs
module i_execute
    import i_execute_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [1:0]          wb_ctl,
    input  logic [2:0]          m_ctl,
    input  logic                regdst,
    input  logic                alusrc,
    input  logic [1:0]          aluop,
    input  logic [DATA_W-1:0]   npc,
    input  logic [DATA_W-1:0]   rdata1,
    input  logic [DATA_W-1:0]   rdata2,
    input  logic [DATA_W-1:0]   s_extend,
    input  logic [REG_W-1:0]    instr_2016,
    input  logic [REG_W-1:0]    instr_1511,
    output logic [1:0]          wb_ctlout,
    output logic [2:0]          m_ctlout,
    output logic [DATA_W-1:0]   add_result,
    output logic                zero,
    output logic [DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]   rdata2out,
    output logic [REG_W-1:0]    five_bit_muxout
);

    logic [3:0]        w_aluCtl;
    logic [DATA_W-1:0] w_aluB;
    logic [DATA_W-1:0] w_aluResult;
    logic [DATA_W-1:0] w_branchTarget;
    logic [REG_W-1:0]  w_destReg;

    logic [1:0]        r_wbCtl;
    logic [2:0]        r_mCtl;
    logic [DATA_W-1:0] r_addResult;
    logic              r_zero;
    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_rdata2;
    logic [REG_W-1:0]  r_destReg;

    alu_control u_alu_control (
        .i_aluop  (aluop),
        .i_funct  (s_extend[5:0]),
        .o_aluctl (w_aluCtl)
    );

    // Operand and destination muxes; branch target is word-offset scaled.
    assign w_aluB         = alusrc ? s_extend : rdata2;
    assign w_destReg      = regdst ? instr_1511 : instr_2016;
    assign w_branchTarget = npc + {s_extend[DATA_W-3:0], 2'b00};

    // ALU: add/sub wrap silently; slt compares as signed values.
    always_comb begin
        w_aluResult = '0;
        case (w_aluCtl)
            ALU_AND: w_aluResult = rdata1 & w_aluB;
            ALU_OR:  w_aluResult = rdata1 | w_aluB;
            ALU_ADD: w_aluResult = rdata1 + w_aluB;
            ALU_SUB: w_aluResult = rdata1 - w_aluB;
            ALU_SLT: w_aluResult = ($signed(rdata1) < $signed(w_aluB)) ? 32'd1 : 32'd0;
            default: w_aluResult = '0;
        endcase
    end

    // EX/MEM register. Stall wins over flush; a flush only zeroes the
    // control fields so the bubble cannot write memory or registers,
    // while the datapath fields are captured as usual.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbCtl     <= '0;
            r_mCtl      <= '0;
            r_addResult <= '0;
            r_zero      <= 1'b0;
            r_aluResult <= '0;
            r_rdata2    <= '0;
            r_destReg   <= '0;
        end else if (!stall) begin
            r_wbCtl     <= flush ? 2'b00  : wb_ctl;
            r_mCtl      <= flush ? 3'b000 : m_ctl;
            r_addResult <= w_branchTarget;
            r_zero      <= (w_aluResult == '0);
            r_aluResult <= w_aluResult;
            r_rdata2    <= rdata2;
            r_destReg   <= w_destReg;
        end
    end

    assign wb_ctlout       = r_wbCtl;
    assign m_ctlout        = r_mCtl;
    assign add_result      = r_addResult;
    assign zero            = r_zero;
    assign alu_result      = r_aluResult;
    assign rdata2out       = r_rdata2;
    assign five_bit_muxout = r_destReg;

endmodule

// File: tb/tb_i_execute.sv
// tb_i_execute: table-driven self-checking bench for i_execute, followed by
// hand-written stall / flush / asynchronous-reset sequences.
module tb_i_execute;

    typedef struct {
        string       name;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        regdst;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] eAdd;
        logic        eZero;
        logic [31:0] eAlu;
        logic [31:0] eRd2;
        logic [4:0]  eDst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extend;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  five_bit_muxout;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    i_execute dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .wb_ctl          (wb_ctl),
        .m_ctl           (m_ctl),
        .regdst          (regdst),
        .alusrc          (alusrc),
        .aluop           (aluop),
        .npc             (npc),
        .rdata1          (rdata1),
        .rdata2          (rdata2),
        .s_extend        (s_extend),
        .instr_2016      (instr_2016),
        .instr_1511      (instr_1511),
        .wb_ctlout       (wb_ctlout),
        .m_ctlout        (m_ctlout),
        .add_result      (add_result),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .five_bit_muxout (five_bit_muxout)
    );

    always #5 clk = ~clk;

    // Drive one vector's inputs onto the DUT.
    task automatic applyStimulus(input vec_t v);
        wb_ctl     = v.wb;
        m_ctl      = v.m;
        regdst     = v.regdst;
        alusrc     = v.alusrc;
        aluop      = v.aluop;
        npc        = v.npc;
        rdata1     = v.rd1;
        rdata2     = v.rd2;
        s_extend   = v.sext;
        instr_2016 = v.rt;
        instr_1511 = v.rd;
    endtask

    // Single comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
        end
    endtask

    // Compare all registered outputs against a vector's expectations;
    // a flushed capture expects cleared control fields.
    task automatic checkVector(input string tag, input vec_t v, input bit flushed);
        checkOutput(tag, "wb_ctlout", {30'd0, wb_ctlout}, flushed ? 32'd0 : {30'd0, v.wb});
        checkOutput(tag, "m_ctlout", {29'd0, m_ctlout}, flushed ? 32'd0 : {29'd0, v.m});
        checkOutput(tag, "add_result", add_result, v.eAdd);
        checkOutput(tag, "zero", {31'd0, zero}, {31'd0, v.eZero});
        checkOutput(tag, "alu_result", alu_result, v.eAlu);
        checkOutput(tag, "rdata2out", rdata2out, v.eRd2);
        checkOutput(tag, "five_bit_muxout", {27'd0, five_bit_muxout}, {27'd0, v.eDst});
    endtask

    task automatic checkCleared(input string tag);
        checkOutput(tag, "wb_ctlout", {30'd0, wb_ctlout}, 32'd0);
        checkOutput(tag, "m_ctlout", {29'd0, m_ctlout}, 32'd0);
        checkOutput(tag, "add_result", add_result, 32'd0);
        checkOutput(tag, "zero", {31'd0, zero}, 32'd0);
        checkOutput(tag, "alu_result", alu_result, 32'd0);
        checkOutput(tag, "rdata2out", rdata2out, 32'd0);
        checkOutput(tag, "five_bit_muxout", {27'd0, five_bit_muxout}, 32'd0);
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name wb m regdst alusrc aluop npc rd1 rd2 sext rt rd | add zero alu rd2 dst
        vecs.push_back('{"radd", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h200, 32'd5, 32'd7,
                         32'h20, 5'd1, 5'd3, 32'h280, 1'b0, 32'd12, 32'd7, 5'd3});
        vecs.push_back('{"beq", 2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'h1234, 32'h1234,
                         32'hFFFFFFFF, 5'd5, 5'd7, 32'hFC, 1'b1, 32'h0, 32'h1234, 5'd5});
        vecs.push_back('{"lw", 2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h40, 32'h1000, 32'hDEAD,
                         32'h10, 5'd9, 5'd2, 32'h80, 1'b0, 32'h1010, 32'hDEAD, 5'd9});
        vecs.push_back('{"slt_neg", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFF, 32'd1,
                         32'h2A, 5'd1, 5'd4, 32'hA8, 1'b0, 32'd1, 32'd1, 5'd4});
        vecs.push_back('{"badfunct", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h10, 32'd5, 32'd3,
                         32'h3F, 5'd1, 5'd6, 32'h10C, 1'b1, 32'd0, 32'd3, 5'd6});
        vecs.push_back('{"sub", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd3, 32'd5,
                         32'h22, 5'd1, 5'd8, 32'h88, 1'b0, 32'hFFFFFFFE, 32'd5, 5'd8});
        vecs.push_back('{"and", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00,
                         32'h24, 5'd1, 5'd10, 32'h90, 1'b0, 32'hF000F000, 32'hFF00FF00, 5'd10});
        vecs.push_back('{"or", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00,
                         32'h25, 5'd1, 5'd11, 32'h94, 1'b0, 32'hFFF0FFF0, 32'hFF00FF00, 5'd11});
        vecs.push_back('{"aluop11", 2'b01, 3'b001, 1'b0, 1'b1, 2'b11, 32'h4, 32'h0, 32'h55,
                         32'hFFFFFFFF, 5'd12, 5'd13, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h55, 5'd12});
        vecs.push_back('{"addovf", 2'b10, 3'b000, 1'b0, 1'b0, 2'b00, 32'h8, 32'h7FFFFFFF, 32'd1,
                         32'h0, 5'd14, 5'd15, 32'h8, 1'b0, 32'h80000000, 32'd1, 5'd14});
        vecs.push_back('{"addwrap", 2'b10, 3'b000, 1'b0, 1'b0, 2'b00, 32'h8, 32'hFFFFFFFF, 32'd1,
                         32'h0, 5'd16, 5'd17, 32'h8, 1'b1, 32'h0, 32'd1, 5'd16});
        vecs.push_back('{"slt_ge", 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'hFFFFFFFF,
                         32'h2A, 5'd1, 5'd18, 32'hA8, 1'b1, 32'd0, 32'hFFFFFFFF, 5'd18});

        // Reset state
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        applyStimulus(vecs[0]);
        #12;
        checkCleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            stepEdge();
            checkVector(vecs[i].name, vecs[i], 1'b0);
        end

        // Stall for two cycles with changing inputs: outputs stay frozen
        @(negedge clk);
        applyStimulus(vecs[0]);
        stepEdge();
        checkVector("pre_stall", vecs[0], 1'b0);
        @(negedge clk);
        stall = 1'b1;
        applyStimulus(vecs[2]);
        stepEdge();
        checkVector("stall1", vecs[0], 1'b0);
        @(negedge clk);
        applyStimulus(vecs[3]);
        stepEdge();
        checkVector("stall2", vecs[0], 1'b0);

        // Flush: control cleared, datapath captured
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b1;
        applyStimulus(vecs[2]);
        stepEdge();
        checkVector("flush", vecs[2], 1'b1);

        // Stall and flush together: hold the flushed state
        @(negedge clk);
        stall = 1'b1;
        applyStimulus(vecs[0]);
        stepEdge();
        checkVector("stall_flush", vecs[2], 1'b1);

        // Release both: normal capture resumes
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        stepEdge();
        checkVector("release", vecs[0], 1'b0);

        // Asynchronous reset between edges clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        checkCleared("async_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[2]);
        stepEdge();
        checkVector("post_rst", vecs[2], 1'b0);

        // Reset asserted during a stall still clears state
        @(negedge clk);
        stall = 1'b1;
        applyStimulus(vecs[5]);
        stepEdge();
        checkVector("stall_hold", vecs[2], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("rst_in_stall");
        @(negedge clk);
        rst = 1'b0;
        stepEdge();
        checkCleared("stall_after_rst");
        @(negedge clk);
        stall = 1'b0;
        stepEdge();
        checkVector("resume", vecs[5], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #20000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
